// File: rtl/priority_encoder_8to3_pkg.sv
// Shared constants, state type and helpers for the 8-to-3 priority encoder.
package priority_encoder_8to3_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned IDX_W   = 3;

    // Capture modes for the EDGE parameter
    localparam bit EDGE_LEVEL = 1'b0;
    localparam bit EDGE_RISE  = 1'b1;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // One-hot mask of a single index, used to clear an acknowledged bit
    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] i_idx);
        logic [NUM_REQ-1:0] v;
        v        = '0;
        v[i_idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/priority_encoder_8to3_if.sv
// Request/handshake bundle between requesters/consumer and the encoder.
interface priority_encoder_8to3_if;
    import priority_encoder_8to3_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic               e;
    logic               ack;
    logic [IDX_W-1:0]   idx;
    logic               valid;
    logic [NUM_REQ-1:0] pending;

    // master: drives requests, enable and acknowledge
    modport master (
        output req, e, ack,
        input  idx, valid, pending
    );

    // slave: the encoder itself
    modport slave (
        input  req, e, ack,
        output idx, valid, pending
    );

endinterface

// File: rtl/priority_encoder_8to3_enc.sv
// Combinational highest-set-bit encoder: bit 7 wins, o_any flags a non-zero input.
module prio_enc_8to3
    import priority_encoder_8to3_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_vec,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    // Ascending scan so the highest set bit is the last one written
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_encoder_8to3.sv
// Registered 8-to-3 priority encoder with sticky request capture and valid/ack handshake.
module priority_encoder_8to3
    import priority_encoder_8to3_pkg::*;
#(
    parameter bit EDGE = EDGE_LEVEL
) (
    input  logic                   clk,
    input  logic                   rst,
    priority_encoder_8to3_if.slave bus
);

    logic [NUM_REQ-1:0] r_req_q;
    logic [NUM_REQ-1:0] r_pending;
    logic [IDX_W-1:0]   r_idx;
    logic               r_valid;
    state_t             r_state;

    logic [NUM_REQ-1:0] w_set_vec;
    logic [NUM_REQ-1:0] w_clr_vec;
    logic [IDX_W-1:0]   w_enc_idx;
    logic               w_enc_any;

    // Selection looks only at the registered pending value
    prio_enc_8to3 u_enc (
        .i_vec (r_pending),
        .o_idx (w_enc_idx),
        .o_any (w_enc_any)
    );

    // Set vector from the capture mode; clear vector from an ack while presenting
    always_comb begin
        w_set_vec = (EDGE == EDGE_RISE) ? (bus.req & ~r_req_q) : bus.req;
        w_clr_vec = '0;
        if (r_state == PRESENT && bus.ack) begin
            w_clr_vec = idx_to_onehot(r_idx);
        end
    end

    // Capture runs every cycle; OR-ing set after the clear makes set win on the same bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_q   <= '0;
            r_pending <= '0;
        end else begin
            r_req_q   <= bus.req;
            r_pending <= (r_pending & ~w_clr_vec) | w_set_vec;
        end
    end

    // Handshake FSM with registered idx/valid; idx frozen while presenting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.e && w_enc_any) begin
                        r_idx   <= w_enc_idx;
                        r_valid <= 1'b1;
                        r_state <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (bus.ack) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.idx     = r_idx;
    assign bus.valid   = r_valid;
    assign bus.pending = r_pending;

endmodule

// File: tb/tb_priority_encoder_8to3.sv
// Bench for priority_encoder_8to3: level and rising-edge instances against a behavioural model.
module tb_priority_encoder_8to3;

    logic       clk;
    logic       rst;
    logic [7:0] t_req;
    logic       t_e;
    logic [1:0] t_ack;

    int n_total;
    int n_bad;

    // model state, index 0 = level capture, index 1 = rising-edge capture
    int m_pend [2];
    int m_idx  [2];
    int m_busy [2];
    int m_prev [2];

    priority_encoder_8to3_if bus0 ();
    priority_encoder_8to3_if bus1 ();

    assign bus0.req = t_req;
    assign bus0.e   = t_e;
    assign bus0.ack = t_ack[0];
    assign bus1.req = t_req;
    assign bus1.e   = t_e;
    assign bus1.ack = t_ack[1];

    priority_encoder_8to3 #(.EDGE(1'b0)) u_dut_lvl (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    priority_encoder_8to3 #(.EDGE(1'b1)) u_dut_edg (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int highest_bit(input int p);
        return $clog2(p + 1) - 1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = 0;
            m_idx[d]  = 0;
            m_busy[d] = 0;
            m_prev[d] = 0;
        end
    endtask

    // one clock edge of the behavioural model, from inputs stable before the edge
    task automatic model_tick();
        int set_v;
        int clr_v;
        for (int d = 0; d < 2; d++) begin
            set_v = (d == 1) ? (int'(t_req) & ~m_prev[d] & 255) : int'(t_req);
            clr_v = 0;
            if (m_busy[d] != 0) begin
                if (t_ack[d]) begin
                    clr_v     = 1 << m_idx[d];
                    m_busy[d] = 0;
                end
            end else if (t_e && m_pend[d] != 0) begin
                m_idx[d]  = highest_bit(m_pend[d]);
                m_busy[d] = 1;
            end
            m_pend[d] = (m_pend[d] & ~clr_v) | set_v;
            m_prev[d] = int'(t_req);
        end
    endtask

    task automatic compare_model();
        check_val("lvl_idx",     32'(bus0.idx),     32'(m_idx[0]));
        check_val("lvl_valid",   32'(bus0.valid),   32'(m_busy[0]));
        check_val("lvl_pending", 32'(bus0.pending), 32'(m_pend[0]));
        check_val("edg_idx",     32'(bus1.idx),     32'(m_idx[1]));
        check_val("edg_valid",   32'(bus1.valid),   32'(m_busy[1]));
        check_val("edg_pending", 32'(bus1.pending), 32'(m_pend[1]));
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        @(negedge clk);
        compare_model();
    endtask

    int cnt0;
    int cnt1;
    logic prev0;
    logic prev1;

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst     = 1'b1;
        t_req   = '0;
        t_e     = 1'b0;
        t_ack   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_idx",     32'(bus0.idx),     32'h0);
        check_val("rst_valid",   32'(bus0.valid),   32'h0);
        check_val("rst_pending", 32'(bus0.pending), 32'h0);
        rst = 1'b0;

        // two requests presented highest first, then a late higher request
        t_e = 1'b1; t_req = 8'b0010_0100;
        step();
        t_req = 8'h00;
        step();
        check_val("s1_valid5", 32'(bus0.valid), 32'h1);
        check_val("s1_idx5",   32'(bus0.idx),   32'h5);
        t_ack = 2'b11; step();
        t_ack = 2'b00; step();
        check_val("s1_idx2", 32'(bus0.idx), 32'h2);
        t_req = 8'h80; step();
        check_val("s1_idx2_hold", 32'(bus0.idx), 32'h2);
        t_req = 8'h00; t_ack = 2'b11; step();
        t_ack = 2'b00; step();
        check_val("s1_idx7", 32'(bus0.idx), 32'h7);
        t_ack = 2'b11; step();
        t_ack = 2'b00; step();
        check_val("s1_empty_pend",  32'(bus0.pending), 32'h0);
        check_val("s1_empty_valid", 32'(bus0.valid),   32'h0);

        // held request with ack high: level re-presents, edge presents once
        cnt0 = 0; cnt1 = 0; prev0 = 1'b0; prev1 = 1'b0;
        t_req = 8'h08; t_ack = 2'b11;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus0.valid && !prev0) cnt0++;
            if (bus1.valid && !prev1) cnt1++;
            prev0 = bus0.valid;
            prev1 = bus1.valid;
        end
        check_val("s2_lvl_presents", 32'(cnt0), 32'd4);
        check_val("s2_edg_presents", 32'(cnt1), 32'd1);
        t_req = 8'h00; step();
        t_ack = 2'b00; step();

        // enable gates presentation but not capture; dropping e mid-handshake is harmless
        t_e = 1'b0; t_req = 8'h81; step();
        t_req = 8'h00; step();
        check_val("s3_pend81",  32'(bus0.pending), 32'h81);
        check_val("s3_novalid", 32'(bus0.valid),   32'h0);
        t_e = 1'b1; step();
        check_val("s3_idx7", 32'(bus0.idx), 32'h7);
        t_e = 1'b0; t_ack = 2'b11; step();
        check_val("s3_pend01", 32'(bus0.pending), 32'h01);

        // ack while idle changes nothing
        step();
        check_val("s4_idle_ack", 32'(bus0.pending), 32'h01);
        t_ack = 2'b00; step();
        t_e = 1'b1; step();
        t_ack = 2'b11; step();
        t_ack = 2'b00;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            t_req    = 8'($urandom & $urandom & $urandom);
            t_e      = ($urandom_range(0, 3) != 0);
            t_ack[0] = 1'($urandom_range(0, 1));
            t_ack[1] = 1'($urandom_range(0, 1));
            step();
        end

        // asynchronous reset in the middle of a presentation
        t_req = 8'hFF; t_e = 1'b1; t_ack = 2'b00;
        repeat (3) step();
        check_val("s6_pendFF", 32'(bus0.pending), 32'hFF);
        check_val("s6_valid",  32'(bus0.valid),   32'h1);
        #2 rst = 1'b1;
        #1;
        check_val("s6_rst_lvl_idx",   32'(bus0.idx),     32'h0);
        check_val("s6_rst_lvl_valid", 32'(bus0.valid),   32'h0);
        check_val("s6_rst_lvl_pend",  32'(bus0.pending), 32'h0);
        check_val("s6_rst_edg_valid", 32'(bus1.valid),   32'h0);
        check_val("s6_rst_edg_pend",  32'(bus1.pending), 32'h0);
        t_req = 8'h00; t_e = 1'b0;
        #1 rst = 1'b0;
        model_reset();
        step();
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // hard time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/priority_encoder_8to3.md
# priority_encoder_8to3

Registered 8-to-3 priority encoder with sticky request capture and a valid/ack handshake; the inverse of the team's 3-to-8 one-hot decoder. It gathers up to eight request lines into a pending register and presents the index of the highest-priority pending request, holding it stable until the consumer acknowledges. It sits in front of the decoder in interrupt/request-routing paths. Its index output can be fed back through the decoder to form a one-hot grant.

## Interface
- `EDGE`, default 0: capture mode. 0 = level (pending |= req every cycle); 1 = rising-edge (pending |= req & ~req_q).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  8  request lines; bit 7 highest priority, bit 0 lowest.
- `e`  in  1  enable; gates launching a new index presentation only.
- `ack`  in  1  consumer acknowledge; meaningful only while `valid`=1.
- `idx`  out  3  encoded index of the presented request.
- `valid`  out  1  `idx` holds a pending request awaiting ack.
- `pending`  out  8  current pending register, registered.

## Operation
- Reset values: `idx`=3'd0, `valid`=0, `pending`=8'h00, req_q=8'h00, state IDLE.
- Capture runs every cycle regardless of `e` or state: set_vec = req (EDGE=0) or req & ~req_q (EDGE=1); req_q <= req.
- FSM, two states:
  - IDLE: `valid`=0. If `e`=1 and pending != 0, then `idx` <= highest set bit of pending and go to PRESENT. Otherwise stay.
  - PRESENT: `valid`=1 and `idx` frozen. If `ack`=1, clear pending[idx], go to IDLE, and drop `valid`. Otherwise stay.
- Pending update per cycle: pending <= (pending & ~clr_vec) | set_vec. clr_vec is one-hot of `idx` on ack in PRESENT, else 0.
- Set wins over clear on the same bit in the same cycle. The request is re-captured and re-presented later.
- A higher-priority request arriving during PRESENT does not change `idx`. It is chosen at the next IDLE→PRESENT transition.
- `e` falling during PRESENT has no effect. The handshake completes normally.
- `ack` in IDLE is ignored: no clear, no state change.
- Priority selection considers the registered pending value only. A request captured in the same cycle as the IDLE decision is not eligible until the next cycle.
- Reset asserted mid-handshake: immediately `valid`=0, `pending`=0, state IDLE. Lost requests are not recovered.

## Timing
- req high sampled at edge N: pending bit set after N; `valid`=1 with `idx` after edge N+1 (if `e`=1). Request-to-valid latency is 2 edges.
- ack sampled with `valid`=1 at edge M: `valid`=0 and bit cleared after M. The next `valid` is earliest after M+1.
- Maximum throughput is one grant per 2 cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- EDGE=1: a held-high req produces exactly one capture. A new capture requires req low for at least one sampled cycle.

## Structure
- Shared package: NUM_REQ=8, IDX_W=3, state enum {IDLE, PRESENT}, EDGE mode constants.
- One sub-module, `prio_enc_8to3`: combinational 8-bit → 3-bit highest-set-bit encoder with an `any` flag. Reused wherever the team needs a priority encode.
- Top holds req_q, pending, FSM and output registers.

## Test plan
- Reset then req=8'b0010_0100 (EDGE=0, e=1), drop req next cycle: `valid` rises 2 edges later with `idx`=5. After ack, `idx`=2. After a second ack, `pending`=0 and `valid` stays 0.
- During PRESENT with `idx`=2, raise req[7]: `idx` stays 2 until ack. The next presentation is `idx`=7.
- EDGE=0, hold req[3] high and ack: bit re-set (set-wins), `valid` returns with `idx`=3. Same stimulus with EDGE=1 yields one presentation only.
- e=0 with req=8'h81: `pending`=8'h81, `valid` stays 0. Raise e: `idx`=7 next presentation. Drop e during PRESENT: ack still clears bit 7.
- ack pulsed while IDLE: `pending` unchanged.
- Assert rst mid-PRESENT with `pending`=8'hFF: all outputs read reset values immediately, with no dependence on a clock edge.
